hub75_bcm_scanner: RTL and testbench

Parametrised successor to the single-bit HUB75 panel scanner, driving a 1:ROWS-scan RGB LED matrix with binary-coded modulation (BCM) for BPP bits per colour channel. Reads two framebuffer ports (top and bottom half) with 1-cycle read latency, shifts one bit plane per pass, latches it, and shows it for a weighted on-time. Sits between the dual-port framebuffer and the PMOD display pins.

---
 rtl/hub75_bcm_scanner.sv | 249 ++++++++++++++++++++++++
 tb/tb_hub75_bcm_scanner.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 1:ROWS scan driver with binary-coded modulation.
// Each scan row is shifted BPP times, once per bit plane, and every plane is
// shown for BASE_ON<<plane ticks so the panel integrates a BPP-bit intensity.
// Optional build macro BRIGHTNESS_EN adds brightness[7:0], which shortens the
// oe_n low window inside each SHOW period without changing frame timing.
// state_dbg exposes the FSM state (IDLE=0, SHIFT=1, LATCH=2, SHOW=3).
//
// Framebuffer read handshake: fixed latency, no backpressure. fb_re is a
// one-cycle strobe qualifying fb_raddr; fb_rdata_top/bot must be valid on the
// cycle immediately after fb_re and are captured on that cycle only.
module hub75_bcm_scanner #(
  parameter int COLS    = 64,
  parameter int ROWS    = 32,
  parameter int BPP     = 4,
  parameter int CLK_DIV = 4,
  parameter int BASE_ON = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
`ifdef BRIGHTNESS_EN
  input  logic [7:0]                             brightness,
`endif
  output logic                                   fb_re,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   fb_raddr,
  input  logic [3*BPP-1:0]                       fb_rdata_top,
  input  logic [3*BPP-1:0]                       fb_rdata_bot,
  output logic                                   r0,
  output logic                                   g0,
  output logic                                   b0,
  output logic                                   r1,
  output logic                                   g1,
  output logic                                   b1,
  output logic [$clog2(ROWS)-1:0]                row_addr,
  output logic                                   display_clk,
  output logic                                   latch,
  output logic                                   oe_n,
  output logic                                   frame_done,
  output logic [1:0]                             state_dbg
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int PW = (BPP > 1) ? $clog2(BPP) : 1;
  localparam int DW = $clog2(CLK_DIV);
  localparam int SW = $clog2((BASE_ON << (BPP - 1)) + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    SHOW  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [DW-1:0]   div;
  logic            tick;
  logic [CW-1:0]   col, col_d, ncol;
  logic [RW-1:0]   row, row_d, nrow;
  logic [PW-1:0]   plane, plane_d;
  logic            phase, phase_d;
  logic [SW-1:0]   cnt, cnt_d;
  logic [SW-1:0]   show_len;
  logic            go_shift;
  logic            re_d;

  logic                 fb_re_d, dclk_d, latch_d, oe_n_d, done_d;
  logic [CW+RW-1:0]     raddr_d;
  logic [RW-1:0]        row_addr_d;

  logic [BPP-1:0] r_top, g_top, b_top, r_bot, g_bot, b_bot;

  assign tick      = (div == '0);
  assign show_len  = SW'(BASE_ON) << plane;
  assign state_dbg = state;

  assign r_top = fb_rdata_top[3*BPP-1:2*BPP];
  assign g_top = fb_rdata_top[2*BPP-1:BPP];
  assign b_top = fb_rdata_top[BPP-1:0];
  assign r_bot = fb_rdata_bot[3*BPP-1:2*BPP];
  assign g_bot = fb_rdata_bot[2*BPP-1:BPP];
  assign b_bot = fb_rdata_bot[BPP-1:0];

`ifdef BRIGHTNESS_EN
  logic [7:0]    bright_q;
  logic [SW+7:0] on_prod;
  logic [SW-1:0] on_len;

  // Ticks of real light in the current plane: floor(show_len*brightness/256).
  assign on_prod = (SW+8)'(show_len) * (SW+8)'(bright_q);
  assign on_len  = on_prod[SW+7:8];

  // Brightness is frozen at LATCH entry so one SHOW period uses one value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) bright_q <= '0;
    else if (tick && (state != LATCH) && (state_d == LATCH)) bright_q <= brightness;
  end
`endif

  // Free-running tick divider; every control change happens when div==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        div <= '0;
    else if (div == DW'(CLK_DIV-1)) div <= '0;
    else                            div <= div + DW'(1);
  end

  // Capture the current plane's colour bits the cycle after each read strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_d <= 1'b0;
      r0 <= 1'b0; g0 <= 1'b0; b0 <= 1'b0;
      r1 <= 1'b0; g1 <= 1'b0; b1 <= 1'b0;
    end else begin
      re_d <= fb_re;
      if (re_d) begin
        r0 <= r_top[plane]; g0 <= g_top[plane]; b0 <= b_top[plane];
        r1 <= r_bot[plane]; g1 <= g_bot[plane]; b1 <= b_bot[plane];
      end
    end
  end

  // FSM next state plus the registered pin values for the coming tick period.
  always_comb begin
    state_d    = state;
    col_d      = col;
    row_d      = row;
    plane_d    = plane;
    phase_d    = phase;
    cnt_d      = cnt;
    fb_re_d    = 1'b0;
    raddr_d    = fb_raddr;
    dclk_d     = display_clk;
    latch_d    = 1'b0;
    oe_n_d     = 1'b1;
    row_addr_d = row_addr;
    done_d     = 1'b0;
    go_shift   = 1'b0;
    nrow       = row;
    ncol       = '0;

    case (state)
      IDLE: begin
        if (enable) begin
          go_shift = 1'b1;
          nrow     = '0;
          plane_d  = '0;
        end
      end
      SHIFT: begin
        if (!phase) begin
          phase_d = 1'b1;
          dclk_d  = 1'b1;
        end else if (col == CW'(COLS-1)) begin
          state_d    = LATCH;
          dclk_d     = 1'b0;
          latch_d    = 1'b1;
          row_addr_d = row;
        end else begin
          go_shift = 1'b1;
          ncol     = col + CW'(1);
        end
      end
      LATCH: begin
        state_d = SHOW;
        cnt_d   = '0;
      end
      SHOW: begin
        if (cnt == show_len - SW'(1)) begin
          if (plane != PW'(BPP-1)) begin
            plane_d  = plane + PW'(1);
            go_shift = 1'b1;
          end else if (row != RW'(ROWS-1)) begin
            plane_d  = '0;
            nrow     = row + RW'(1);
            go_shift = 1'b1;
          end else begin
            done_d  = 1'b1;
            plane_d = '0;
            row_d   = '0;
            nrow    = '0;
            if (enable) go_shift = 1'b1;
            else        state_d  = IDLE;
          end
        end else begin
          cnt_d = cnt + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Entering phase 0 of a pixel: strobe the read and drop the shift clock.
    if (go_shift) begin
      state_d = SHIFT;
      phase_d = 1'b0;
      col_d   = ncol;
      row_d   = nrow;
      fb_re_d = 1'b1;
      raddr_d = {nrow, ncol};
      dclk_d  = 1'b0;
    end

    // Light only while staying in SHOW; the dimmed tail stays blank.
    if (state_d == SHOW) begin
`ifdef BRIGHTNESS_EN
      oe_n_d = (cnt_d >= on_len);
`else
      oe_n_d = 1'b0;
`endif
    end
  end

  // State, counters and panel pins advance on ticks; strobes last one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      plane       <= '0;
      phase       <= 1'b0;
      cnt         <= '0;
      fb_re       <= 1'b0;
      fb_raddr    <= '0;
      display_clk <= 1'b0;
      latch       <= 1'b0;
      oe_n        <= 1'b1;
      row_addr    <= '0;
      frame_done  <= 1'b0;
    end else begin
      fb_re      <= 1'b0;
      frame_done <= 1'b0;
      if (tick) begin
        state       <= state_d;
        col         <= col_d;
        row         <= row_d;
        plane       <= plane_d;
        phase       <= phase_d;
        cnt         <= cnt_d;
        fb_re       <= fb_re_d;
        fb_raddr    <= raddr_d;
        display_clk <= dclk_d;
        latch       <= latch_d;
        oe_n        <= oe_n_d;
        row_addr    <= row_addr_d;
        frame_done  <= done_d;
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: randomized framebuffer contents checked against a
// frame-level model of the expected pixel/address/row/on-time sequences.
module tb_hub75_bcm_scanner;

  localparam int COLS    = 4;
  localparam int ROWS    = 2;
  localparam int BPP     = 2;
  localparam int CLK_DIV = 3;
  localparam int BASE_ON = 2;
  localparam int AW      = $clog2(ROWS) + $clog2(COLS);
  localparam int FRAME_CYC = CLK_DIV * ROWS * (BPP * (2 * COLS + 1) + BASE_ON * ((1 << BPP) - 1));

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst, enable;
  logic fb_re, r0, g0, b0, r1, g1, b1, display_clk, latch, oe_n, frame_done;
  logic [AW-1:0] fb_raddr;
  logic [3*BPP-1:0] fb_rdata_top, fb_rdata_bot;
  logic [$clog2(ROWS)-1:0] row_addr;
  logic [1:0] state_dbg;
`ifdef BRIGHTNESS_EN
  logic [7:0] brightness;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  hub75_bcm_scanner #(
    .COLS(COLS), .ROWS(ROWS), .BPP(BPP), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .fb_re(fb_re), .fb_raddr(fb_raddr),
    .fb_rdata_top(fb_rdata_top), .fb_rdata_bot(fb_rdata_bot),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .row_addr(row_addr), .display_clk(display_clk), .latch(latch),
    .oe_n(oe_n), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // Framebuffer model: one-cycle read latency.
  logic [3*BPP-1:0] mem_top [1<<AW];
  logic [3*BPP-1:0] mem_bot [1<<AW];
  always @(posedge clk) begin
    if (fb_re) begin
      fb_rdata_top <= mem_top[fb_raddr];
      fb_rdata_bot <= mem_bot[fb_raddr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            row_q[$];
  int            on_q[$];
  int br_model = 256;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_pix(input int a, input int p);
    int t, b, v;
    t = int'(mem_top[a]);
    b = int'(mem_bot[a]);
    v = ((t >> (2*BPP + p)) & 1) * 32 + ((t >> (BPP + p)) & 1) * 16 + ((t >> p) & 1) * 8
      + ((b >> (2*BPP + p)) & 1) * 4 + ((b >> (BPP + p)) & 1) * 2 + ((b >> p) & 1);
    return 6'(v);
  endfunction

  // Expected observable sequence of one whole frame.
  task automatic build_frame();
    int on;
    for (int r = 0; r < ROWS; r++) begin
      for (int p = 0; p < BPP; p++) begin
        for (int c = 0; c < COLS; c++) begin
          exp_q.push_back(model_pix(r * COLS + c, p));
          addr_q.push_back(AW'(r * COLS + c));
        end
        row_q.push_back(r);
        on = ((BASE_ON << p) * br_model) / 256;
        if (on > 0) on_q.push_back(on * CLK_DIV);
      end
    end
  endtask

  task automatic fill_mem();
    for (int a = 0; a < (1 << AW); a++) begin
      mem_top[a] = (3*BPP)'($urandom_range(0, (1 << (3*BPP)) - 1));
      mem_bot[a] = (3*BPP)'($urandom_range(0, (1 << (3*BPP)) - 1));
    end
  endtask

  // ---------------- monitor ----------------
  logic mon_en = 1'b0;
  logic prev_dclk = 1'b0, prev_re = 1'b0, prev_latch = 1'b0, prev_done = 1'b0;
  logic [5:0] prev_pix = '0;
  int cyc = 0, last_done_t = -1, low_run = 0;
  int dclk_rises = 0, re_cnt = 0, done_cnt = 0, viol = 0;

  always @(negedge clk) begin
    logic [5:0] cur;
    cyc++;
    cur = {r0, g0, b0, r1, g1, b1};
    if (mon_en) begin
      if (display_clk && !prev_dclk) begin
        dclk_rises++;
        check("pix_stable", cur, prev_pix);
        if (exp_q.size() == 0) check("pix_extra", 1, 0);
        else check("pix", cur, exp_q.pop_front());
      end
      if (fb_re) begin
        re_cnt++;
        if (prev_re) viol++;
        if (addr_q.size() == 0) check("addr_extra", 1, 0);
        else check("fb_raddr", fb_raddr, addr_q.pop_front());
      end
      if (latch && !prev_latch) begin
        if (row_q.size() == 0) check("latch_extra", 1, 0);
        else check("row_addr", row_addr, row_q.pop_front());
      end
      if (!oe_n && (latch || fb_re || display_clk)) viol++;
      if (latch && display_clk) viol++;
      if (!oe_n) low_run++;
      else if (low_run > 0) begin
        if (on_q.size() == 0) check("oe_extra", low_run, 0);
        else check("oe_on_cycles", low_run, on_q.pop_front());
        low_run = 0;
      end
      if (frame_done) begin
        done_cnt++;
        if (prev_done) viol++;
        if (last_done_t >= 0) check("frame_period", cyc - last_done_t, FRAME_CYC);
        last_done_t = cyc;
      end
      prev_dclk  = display_clk;
      prev_re    = fb_re;
      prev_latch = latch;
      prev_done  = frame_done;
      prev_pix   = cur;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int n, input int budget);
    for (int k = 0; k < budget && done_cnt < n; k++) @(negedge clk);
    check("frame_count", done_cnt, n);
  endtask

  task automatic end_checks(input int frames);
    check("pix_left", exp_q.size(), 0);
    check("addr_left", addr_q.size(), 0);
    check("row_left", row_q.size(), 0);
    check("on_left", on_q.size(), 0);
    check("safety_viol", viol, 0);
    check("dclk_rises", dclk_rises, frames * ROWS * BPP * COLS);
    check("re_per_dclk", re_cnt, dclk_rises);
  endtask

  task automatic start_phase(input int frames);
    exp_q.delete(); addr_q.delete(); row_q.delete(); on_q.delete();
    dclk_rises = 0; re_cnt = 0; done_cnt = 0; viol = 0; low_run = 0; last_done_t = -1;
    for (int f = 0; f < frames; f++) build_frame();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int act, re0;
    rst = 1'b1;
    enable = 1'b0;
    fb_rdata_top = '0;
    fb_rdata_bot = '0;
`ifdef BRIGHTNESS_EN
    brightness = 8'd128;
    br_model = 128;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n", oe_n, 1);
    check("rst_latch", latch, 0);
    check("rst_dclk", display_clk, 0);
    check("rst_fb_re", fb_re, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_rgb", {r0, g0, b0, r1, g1, b1}, 0);

    // Phase 1: three frames, enable dropped ~10 ticks into the third.
    fill_mem();
    mem_top[0] = 6'b10_01_11;
    start_phase(3);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    wait_done(2, 2 * FRAME_CYC + 4 * CLK_DIV);
    repeat (10 * CLK_DIV) @(negedge clk);
    enable = 1'b0;
    wait_done(3, FRAME_CYC);
    re0 = re_cnt;
    act = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!oe_n || fb_re || latch || display_clk) act++;
    end
    check("idle_activity", act, 0);
    check("idle_re", re_cnt - re0, 0);
    check("idle_state", state_dbg, 0);
    check("idle_frames", done_cnt, 3);
    check("idle_low_run", low_run, 0);
    end_checks(3);

    // Phase 2: reset asserted while the panel is lit.
    mon_en = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 2 * FRAME_CYC && oe_n; k++) @(posedge clk);
    check("reached_show", oe_n, 0);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_oe_n", oe_n, 1);
    check("mid_rst_dclk", display_clk, 0);
    check("mid_rst_latch", latch, 0);
    check("mid_rst_row_addr", row_addr, 0);
    check("mid_rst_fb_re", fb_re, 0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    act = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!oe_n || fb_re || latch) act++;
    end
    check("post_rst_idle", act, 0);

    // Phase 3: fresh contents (and brightness), two frames after restart.
    fill_mem();
`ifdef BRIGHTNESS_EN
    brightness = 8'($urandom_range(0, 255));
    br_model = int'(brightness);
`endif
    start_phase(2);
    mon_en = 1'b1;
    enable = 1'b1;
    wait_done(1, FRAME_CYC + 4 * CLK_DIV);
    repeat ($urandom_range(1, FRAME_CYC - 10)) @(negedge clk);
    enable = 1'b0;
    wait_done(2, FRAME_CYC);
    repeat (50) @(negedge clk);
    check("final_frames", done_cnt, 2);
    check("final_low_run", low_run, 0);
    end_checks(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
